// File: rtl/arith_unit.sv
// arith_unit: multi-cycle signed fixed-point ADD/MUL/DIV with start/busy/done handshake.
// Optional macro AU_SAT_EN: clamp RQ on overflow instead of wrapping to the low W bits.
module arith_unit #(
  parameter int W    = 24,
  parameter int FRAC = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] R,
  input  logic [W-1:0] S,
  input  logic [W-1:0] I,
  input  logic         msb_R,
  input  logic         msb_S,
  output logic [W-1:0] RQ,
  output logic [W-1:0] RD,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic         div0
);

  localparam int QW = W + FRAC;
  localparam int PW = 2 * W;
  localparam int MW = ((PW - FRAC) > QW) ? (PW - FRAC) : QW;
  localparam int CW = $clog2(QW);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

  localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [MW-1:0] LIM_POS = MW'(MAX_POS);
  localparam logic [MW-1:0] LIM_NEG = MW'(MIN_NEG);

  logic [1:0]    r_state;
  logic [1:0]    r_op;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_i;
  logic          r_sign;
  logic          r_msb_r;
  logic          r_div0;
  logic [PW:0]   r_acc;
  logic [QW-1:0] r_dq;
  logic [W-1:0]  r_rem;

  logic [1:0]    w_op;
  logic [W-1:0]  w_mag_r;
  logic [W-1:0]  w_mag_s;
  logic          w_div0;
  logic [CW-1:0] w_cnt_init;
  logic [W:0]    w_hi_add;
  logic [W:0]    w_rem_sh;
  logic          w_ge;
  logic [W+1:0]  w_sum;
  logic          w_add_ovf;
  logic [MW-1:0] w_mag_q;
  logic          w_md_ovf;
  logic [W-1:0]  w_mag_lo;
  logic [W-1:0]  w_md_res;
  logic [W-1:0]  w_rq;
  logic [W-1:0]  w_rd;
  logic          w_ovf;

  // Operand decode at the accepting edge
  always_comb begin
    w_op    = (op == 2'b11) ? OP_ADD : op;
    w_mag_r = msb_R ? ('0 - R) : R;
    w_mag_s = msb_S ? ('0 - S) : S;
    w_div0  = (w_op == OP_DIV) && (S == '0);
    case (w_op)
      OP_MUL:  w_cnt_init = CW'(W - 1);
      OP_DIV:  w_cnt_init = w_div0 ? '0 : CW'(QW - 1);
      default: w_cnt_init = '0;
    endcase
  end

  // One shift-add step (multiplier in the low half of r_acc) and one restoring-divide step
  always_comb begin
    w_hi_add = r_acc[PW:W] + (r_acc[0] ? {1'b0, r_a} : '0);
    w_rem_sh = {r_rem, r_dq[QW-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_b});
  end

  always_comb begin
    w_sum     = {{2{r_a[W-1]}}, r_a} + {{2{r_b[W-1]}}, r_b} + {{2{r_i[W-1]}}, r_i};
    w_add_ovf = (w_sum[W+1:W-1] != 3'b000) && (w_sum[W+1:W-1] != 3'b111);
    w_mag_q   = (r_op == OP_MUL) ? MW'(r_acc[PW-1:FRAC]) : MW'(r_dq);
    w_md_ovf  = r_sign ? (w_mag_q > LIM_NEG) : (w_mag_q > LIM_POS);
    w_mag_lo  = w_mag_q[W-1:0];
    w_md_res  = r_sign ? ('0 - w_mag_lo) : w_mag_lo;
    w_rq      = '0;
    w_rd      = '0;
    w_ovf     = 1'b0;
    if (r_div0) begin
      w_rq  = r_msb_r ? MIN_NEG : MAX_POS;
      w_ovf = 1'b1;
    end else if (r_op == OP_ADD) begin
      w_rq  = w_sum[W-1:0];
      w_ovf = w_add_ovf;
`ifdef AU_SAT_EN
      if (w_add_ovf) w_rq = w_sum[W+1] ? MIN_NEG : MAX_POS;
`endif
    end else begin
      w_rq  = w_md_res;
      w_rd  = (r_op == OP_MUL) ? r_acc[W-1:0] : r_rem;
      w_ovf = w_md_ovf;
`ifdef AU_SAT_EN
      if (w_md_ovf) w_rq = r_sign ? MIN_NEG : MAX_POS;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_i     <= '0;
      r_sign  <= 1'b0;
      r_msb_r <= 1'b0;
      r_div0  <= 1'b0;
      r_acc   <= '0;
      r_dq    <= '0;
      r_rem   <= '0;
      RQ      <= '0;
      RD      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      div0    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // div0 still passes through one idle RUN cycle so its latency matches ADD
            r_state <= ST_RUN;
            r_op    <= w_op;
            r_cnt   <= w_cnt_init;
            r_a     <= (w_op == OP_ADD) ? R : w_mag_r;
            r_b     <= (w_op == OP_ADD) ? S : w_mag_s;
            r_i     <= I;
            r_sign  <= msb_R ^ msb_S;
            r_msb_r <= msb_R;
            r_div0  <= w_div0;
            r_acc   <= {{(W+1){1'b0}}, w_mag_s};
            r_dq    <= {w_mag_r, {FRAC{1'b0}}};
            r_rem   <= '0;
            busy    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!r_div0) begin
            case (r_op)
              OP_MUL: r_acc <= {1'b0, w_hi_add, r_acc[W-1:1]};
              OP_DIV: begin
                r_rem <= w_ge ? W'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[W-1:0];
                r_dq  <= {r_dq[QW-2:0], w_ge};
              end
              default: ;
            endcase
          end
          if (r_cnt == '0) r_state <= ST_FIX;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
          RQ      <= w_rq;
          RD      <= w_rd;
          ovf     <= w_ovf;
          div0    <= r_div0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_unit.sv
// tb_arith_unit: directed and randomized checks of arith_unit against a behavioural arithmetic model.
`timescale 1ns/1ps
module tb_arith_unit;
  localparam int W    = 24;
  localparam int FRAC = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = '0;
  logic [W-1:0] R = '0;
  logic [W-1:0] S = '0;
  logic [W-1:0] I = '0;
  logic         msb_R = 1'b0;
  logic         msb_S = 1'b0;
  logic [W-1:0] RQ;
  logic [W-1:0] RD;
  logic         busy;
  logic         done;
  logic         ovf;
  logic         div0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arith_unit #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .R(R), .S(S), .I(I), .msb_R(msb_R), .msb_S(msb_S),
    .RQ(RQ), .RD(RD), .busy(busy), .done(done), .ovf(ovf), .div0(div0)
  );

  // Reference: plain integer arithmetic on signed values and sign/magnitude pairs
  function automatic void model(input logic [1:0] f_op, input logic [W-1:0] a, b, c,
                                input logic ma, mb,
                                output logic [W-1:0] e_rq, e_rd,
                                output logic e_ovf, e_div0, output int e_lat);
    longint lim  = longint'(1) << (W-1);
    longint modw = longint'(1) << W;
    longint ar, bs, m, v, sum, p;
    logic   neg;
    e_div0 = 1'b0;
    e_rd   = '0;
    if (f_op == 2'd2 && b == '0) begin
      e_div0 = 1'b1;
      e_ovf  = 1'b1;
      e_rq   = ma ? W'(lim) : W'(lim - 1);
      e_lat  = 2;
    end else if (f_op == 2'd1 || f_op == 2'd2) begin
      ar  = ma ? (modw - longint'(a)) % modw : longint'(a);
      bs  = mb ? (modw - longint'(b)) % modw : longint'(b);
      neg = ma ^ mb;
      if (f_op == 2'd1) begin
        p     = ar * bs;
        m     = p >> FRAC;
        e_rd  = W'(p % modw);
        e_lat = W + 1;
      end else begin
        m     = (ar << FRAC) / bs;
        e_rd  = W'((ar << FRAC) % bs);
        e_lat = W + FRAC + 1;
      end
      e_ovf = neg ? (m > lim) : (m > lim - 1);
      v     = neg ? -m : m;
      e_rq  = W'(v);
`ifdef AU_SAT_EN
      if (e_ovf) e_rq = neg ? W'(lim) : W'(lim - 1);
`endif
    end else begin
      sum   = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c));
      e_ovf = (sum > lim - 1) || (sum < -lim);
      e_rq  = W'(sum);
`ifdef AU_SAT_EN
      if (e_ovf) e_rq = (sum < 0) ? W'(lim) : W'(lim - 1);
`endif
      e_lat = 2;
    end
  endfunction

  function automatic logic [W-1:0] rnd_val();
    logic [W-1:0] v;
    v = W'($urandom >> $urandom_range(0, 23));
    if ($urandom_range(0, 1) == 1) v = '0 - v;
    return v;
  endfunction

  task automatic do_op(input logic [1:0] t_op, input logic [W-1:0] a, b, c, input logic ma, mb,
                       output logic [W-1:0] o_rq, o_rd, output logic o_ovf, o_div0,
                       output int lat);
    @(negedge clk);
    op = t_op; R = a; S = b; I = c; msb_R = ma; msb_S = mb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    o_rq = RQ; o_rd = RD; o_ovf = ovf; o_div0 = div0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_vec++;
    if ({RQ, RD, busy, done, ovf, div0} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got RQ=%h RD=%h busy=%b done=%b ovf=%b div0=%b, expected all 0",
               RQ, RD, busy, done, ovf, div0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_add;
    @(negedge clk);
    op = 2'd0; R = 24'h000100; S = 24'h000200; I = 24'h000001; msb_R = 1'b0; msb_S = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      n_vec++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL add_busy_cycle%0d: got busy=%b done=%b, expected 1 0", c, busy, done);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL add_done_edge2: got done=%b busy=%b, expected 1 0", done, busy);
    end
    n_vec++;
    if (RQ !== 24'h000301 || RD !== '0 || ovf !== 1'b0 || div0 !== 1'b0) begin
      n_err++;
      $display("FAIL add_result: got RQ=%h RD=%h ovf=%b div0=%b, expected 000301 000000 0 0",
               RQ, RD, ovf, div0);
    end
    @(posedge clk); #1;
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL add_done_pulse: got done=%b, expected 0", done);
    end
  endtask

  task automatic test_mul;
    int lat;
    @(negedge clk);
    op = 2'd1; R = 24'h001800; S = 24'hFFE000; I = '0; msb_R = 1'b0; msb_S = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 3) begin
        op = 2'd0; R = 24'h7FFFFF; S = 24'h000123; start = 1'b1;
      end
      if (lat == 4) start = 1'b0;
      if (done) break;
    end
    n_vec++;
    if (lat != W + 1) begin
      n_err++;
      $display("FAIL mul_latency: got %0d edges, expected %0d", lat, W + 1);
    end
    n_vec++;
    if (RQ !== 24'hFFD000 || RD !== 24'h000000 || ovf !== 1'b0 || div0 !== 1'b0) begin
      n_err++;
      $display("FAIL mul_result: got RQ=%h RD=%h ovf=%b div0=%b, expected FFD000 000000 0 0",
               RQ, RD, ovf, div0);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL mul_start_ignored: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic [W-1:0] g_rq, g_rd;
    logic         g_ovf, g_div0;
    int           lat;
    @(negedge clk);
    op = 2'd1; R = 24'h001800; S = 24'hFFE000; I = '0; msb_R = 1'b0; msb_S = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midmul_busy: got busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({RQ, RD, busy, done, ovf, div0} !== '0) begin
      n_err++;
      $display("FAIL midmul_reset: got RQ=%h RD=%h busy=%b done=%b ovf=%b div0=%b, expected all 0",
               RQ, RD, busy, done, ovf, div0);
    end
    @(negedge clk); rst_n = 1'b1;
    do_op(2'd0, 24'h000010, 24'h000020, 24'h000003, 1'b0, 1'b0, g_rq, g_rd, g_ovf, g_div0, lat);
    n_vec++;
    if (lat != 2 || g_rq !== 24'h000033 || g_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_add: got lat=%0d RQ=%h ovf=%b, expected 2 000033 0", lat, g_rq, g_ovf);
    end
  endtask

  task automatic test_div;
    logic [W-1:0] g_rq, g_rd;
    logic         g_ovf, g_div0;
    int           lat;
    do_op(2'd2, 24'h003000, 24'h002000, '0, 1'b0, 1'b0, g_rq, g_rd, g_ovf, g_div0, lat);
    n_vec++;
    if (lat != W + FRAC + 1) begin
      n_err++;
      $display("FAIL div_latency: got %0d edges, expected %0d", lat, W + FRAC + 1);
    end
    n_vec++;
    if (g_rq !== 24'h001800 || g_rd !== '0 || g_ovf !== 1'b0 || g_div0 !== 1'b0) begin
      n_err++;
      $display("FAIL div_result: got RQ=%h RD=%h ovf=%b div0=%b, expected 001800 000000 0 0",
               g_rq, g_rd, g_ovf, g_div0);
    end
  endtask

  task automatic test_div0;
    logic [W-1:0] g_rq, g_rd;
    logic         g_ovf, g_div0;
    int           lat;
    do_op(2'd2, 24'hFF0000, '0, '0, 1'b1, 1'b0, g_rq, g_rd, g_ovf, g_div0, lat);
    n_vec++;
    if (lat != 2 || g_div0 !== 1'b1 || g_ovf !== 1'b1 || g_rq !== 24'h800000 || g_rd !== '0) begin
      n_err++;
      $display("FAIL div0: got lat=%0d div0=%b ovf=%b RQ=%h RD=%h, expected 2 1 1 800000 000000",
               lat, g_div0, g_ovf, g_rq, g_rd);
    end
  endtask

  task automatic test_add_ovf;
    logic [W-1:0] g_rq, g_rd, e_rq;
    logic         g_ovf, g_div0;
    int           lat;
`ifdef AU_SAT_EN
    e_rq = 24'h7FFFFF;
`else
    e_rq = 24'h800000;
`endif
    do_op(2'd0, 24'h7FFFFF, '0, 24'h000001, 1'b0, 1'b0, g_rq, g_rd, g_ovf, g_div0, lat);
    n_vec++;
    if (g_ovf !== 1'b1 || g_rq !== e_rq || lat != 2) begin
      n_err++;
      $display("FAIL add_ovf: got ovf=%b RQ=%h lat=%0d, expected 1 %h 2", g_ovf, g_rq, lat, e_rq);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] g_rq, g_rd, e_rq, e_rd;
    logic         g_ovf, g_div0, e_ovf, e_div0;
    int           lat, e_lat;
    do_op(2'd0, 24'h000005, 24'h000006, 24'h000007, 1'b0, 1'b0, g_rq, g_rd, g_ovf, g_div0, lat);
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || g_rq !== 24'h000012) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b busy=%b RQ=%h, expected 1 0 000012", done, busy, g_rq);
    end
    op = 2'd1; R = 24'h002000; S = 24'h000800; I = '0; msb_R = 1'b0; msb_S = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b, expected 1", busy);
    end
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    model(2'd1, 24'h002000, 24'h000800, '0, 1'b0, 1'b0, e_rq, e_rd, e_ovf, e_div0, e_lat);
    n_vec++;
    if (lat != e_lat || RQ !== e_rq || RD !== e_rd || ovf !== e_ovf) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d RQ=%h RD=%h ovf=%b, expected %0d %h %h %b",
               lat, RQ, RD, ovf, e_lat, e_rq, e_rd, e_ovf);
    end
  endtask

  task automatic test_random;
    logic [1:0]   t_op;
    logic [W-1:0] a, b, c, g_rq, g_rd, e_rq, e_rd;
    logic         g_ovf, g_div0, e_ovf, e_div0;
    int           lat, e_lat;
    for (int n = 0; n < 60; n++) begin
      t_op = 2'($urandom_range(0, 3));
      a    = rnd_val();
      b    = ($urandom_range(0, 7) == 0) ? '0 : rnd_val();
      c    = rnd_val();
      model(t_op, a, b, c, a[W-1], b[W-1], e_rq, e_rd, e_ovf, e_div0, e_lat);
      do_op(t_op, a, b, c, a[W-1], b[W-1], g_rq, g_rd, g_ovf, g_div0, lat);
      n_vec++;
      if (lat != e_lat || g_rq !== e_rq || g_rd !== e_rd || g_ovf !== e_ovf || g_div0 !== e_div0) begin
        n_err++;
        $display("FAIL rand%0d op=%0d R=%h S=%h I=%h: got lat=%0d RQ=%h RD=%h ovf=%b div0=%b, expected %0d %h %h %b %b",
                 n, t_op, a, b, c, lat, g_rq, g_rd, g_ovf, g_div0, e_lat, e_rq, e_rd, e_ovf, e_div0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add;
    test_mul;
    test_reset_mid_mul;
    test_div;
    test_div0;
    test_add_ovf;
    test_back_to_back;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
